pong_game_ctrl: RTL and testbench

Game-flow sequencer for the Pong top level. Gates the bar/ball motion datapath (run enable, serve pulse, serve direction) from frame timing, start button and miss events. Keeps both scores and detects game over. Sits between VH_GENERATOR (v_synch), the button inputs and bar_ball; its score outputs feed a score overlay.

---
 rtl/pong_game_ctrl_pkg.sv | 24 ++
 rtl/pong_game_ctrl_if.sv | 31 +++
 rtl/pong_game_ctrl_frame_timer.sv | 45 ++++
 rtl/pong_game_ctrl.sv | 134 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared state codes and default timing for the Pong game-flow controller.
// Constants only: no latency, no backpressure.
package pong_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;
  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SCORE_W      = 4;

  function automatic int frame_cnt_w(input int serve_frames, input int point_frames);
    int m;
    m = (serve_frames > point_frames) ? serve_frames : point_frames;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Controller bundle: timing/button/miss inputs in, motion gating and scores out.
// Plain wires: no latency, no backpressure.
interface pong_game_ctrl_if
  import pong_game_ctrl_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
);
  logic                      v_synch;
  logic                      btn_start;
  logic                      miss_left;
  logic                      miss_right;
  logic                      run_en;
  logic                      ball_serve;
  logic                      serve_dir;
  logic [SCORE_W-1:0]        score_left;
  logic [SCORE_W-1:0]        score_right;
  logic                      game_over;
  logic                      winner;
  logic [$bits(state_t)-1:0] state;

  modport master (
    output v_synch, btn_start, miss_left, miss_right,
    input  run_en, ball_serve, serve_dir, score_left, score_right, game_over, winner, state
  );

  modport slave (
    input  v_synch, btn_start, miss_left, miss_right,
    output run_en, ball_serve, serve_dir, score_left, score_right, game_over, winner, state
  );

endinterface

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame tick from v_synch falling edge and per-state frame counter with terminal compare.
// done is combinational on the tick cycle; no backpressure.
module pong_frame_timer #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W        = 7
) (
  input  logic Clock,
  input  logic Reset,
  input  logic v_synch,
  input  logic clear,
  input  logic sel_point,
  output logic frame_tick,
  output logic done
);

  localparam logic [CNT_W-1:0] SERVE_T = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_T = CNT_W'(POINT_FRAMES);

  logic             v_synch_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] target;

  assign frame_tick = v_synch_q & ~v_synch;
  assign cnt_inc    = frame_cnt + CNT_W'(1);
  assign target     = sel_point ? POINT_T : SERVE_T;
  // clear wins over a same-cycle tick, so the tick that coincides with a state change is dropped
  assign done       = ~clear & frame_tick & (cnt_inc == target);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      v_synch_q <= 1'b0;
      frame_cnt <= '0;
    end else begin
      v_synch_q <= v_synch;
      if (clear || done) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        frame_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: gates bar_ball motion, issues serve pulses, keeps scores and game over.
// Acts one cycle after an input event (start: 3 cycles via synchroniser); no backpressure.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input logic              Clock,
  input logic              Reset,
  pong_game_ctrl_if.slave  bus
);

  localparam int                 CNT_W = frame_cnt_w(SERVE_FRAMES, POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_SCORE);

  state_t             st;
  logic               run_en, ball_serve, serve_dir, game_over, winner;
  logic [SCORE_W-1:0] score_left, score_right, score_l_inc, score_r_inc;
  logic [2:0]         start_sync;
  logic               miss_l_q, miss_r_q;
  logic               start_evt, miss_l_evt, miss_r_evt;
  logic               frame_tick, done;

  assign start_evt   = start_sync[1] & ~start_sync[2];
  assign miss_l_evt  = bus.miss_left  & ~miss_l_q;
  assign miss_r_evt  = bus.miss_right & ~miss_r_q;
  assign score_l_inc = (score_left  >= WIN_T) ? score_left  : score_left  + SCORE_W'(1);
  assign score_r_inc = (score_right >= WIN_T) ? score_right : score_right + SCORE_W'(1);

  pong_frame_timer #(
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .CNT_W        (CNT_W)
  ) u_frame_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .v_synch    (bus.v_synch),
    .clear      (!(st == ST_SERVE || st == ST_POINT)),
    .sel_point  (st == ST_POINT),
    .frame_tick (frame_tick),
    .done       (done)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      start_sync  <= '0;
      miss_l_q    <= 1'b0;
      miss_r_q    <= 1'b0;
      st          <= ST_IDLE;
      run_en      <= 1'b0;
      ball_serve  <= 1'b0;
      serve_dir   <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], bus.btn_start};
      miss_l_q   <= bus.miss_left;
      miss_r_q   <= bus.miss_right;
      ball_serve <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start_evt) begin
            score_left  <= '0;
            score_right <= '0;
            serve_dir   <= 1'b0;
            game_over   <= 1'b0;
            st          <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (frame_tick && done) begin
            st         <= ST_PLAY;
            run_en     <= 1'b1;
            ball_serve <= 1'b1;
          end
        end
        ST_PLAY: begin
          // a double miss is a dead ball: re-serve without scoring
          if (miss_l_evt && miss_r_evt) begin
            st     <= ST_SERVE;
            run_en <= 1'b0;
          end else if (miss_l_evt) begin
            score_right <= score_r_inc;
            serve_dir   <= 1'b0;
            run_en      <= 1'b0;
            if (score_r_inc == WIN_T) begin
              st        <= ST_OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              st <= ST_POINT;
            end
          end else if (miss_r_evt) begin
            score_left <= score_l_inc;
            serve_dir  <= 1'b1;
            run_en     <= 1'b0;
            if (score_l_inc == WIN_T) begin
              st        <= ST_OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              st <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (frame_tick && done) begin
            st <= ST_SERVE;
          end
        end
        default: begin
          st        <= ST_IDLE;
          run_en    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run_en      = run_en;
  assign bus.ball_serve  = ball_serve;
  assign bus.serve_dir   = serve_dir;
  assign bus.score_left  = score_left;
  assign bus.score_right = score_right;
  assign bus.game_over   = game_over;
  assign bus.winner      = winner;
  assign bus.state       = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a table of game actions with expected outputs,
// followed by hand sequences for start latency, serve pulse width, held miss and async reset.
module tb_pong_game_ctrl;

  typedef enum int {A_START, A_FRAME, A_MISS_L, A_MISS_R, A_MISS_B} act_t;

  typedef struct {
    act_t act;
    int   n;
    int   st;
    int   run;
    int   sl;
    int   sr;
    int   dir;
    int   over;
    int   win;
  } vec_t;

  logic Clock;
  logic Reset;
  int   n_total;
  int   n_pass;
  vec_t vecs[$];

  pong_game_ctrl_if #(.SCORE_W(4)) bus();

  pong_game_ctrl #(
    .SERVE_FRAMES (2),
    .POINT_FRAMES (3),
    .WIN_SCORE    (3),
    .SCORE_W      (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic add(input act_t a, input int n, input int st, input int run, input int sl,
                     input int sr, input int dir, input int over, input int win);
    vec_t v;
    v = '{a, n, st, run, sl, sr, dir, over, win};
    vecs.push_back(v);
  endtask

  task automatic do_frame(input int n);
    for (int k = 0; k < n; k++) begin
      bus.v_synch = 1'b0;
      step(2);
      bus.v_synch = 1'b1;
      step(2);
    end
  endtask

  task automatic do_start();
    bus.btn_start = 1'b1;
    step(6);
    bus.btn_start = 1'b0;
    step(4);
  endtask

  task automatic do_miss(input logic l, input logic r);
    bus.miss_left  = l;
    bus.miss_right = r;
    step(3);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    step(2);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_run_en"}, int'(bus.run_en), 0);
    check({tag, "_score_l"}, int'(bus.score_left), 0);
    check({tag, "_score_r"}, int'(bus.score_right), 0);
    check({tag, "_game_over"}, int'(bus.game_over), 0);
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    Reset          = 1'b0;
    bus.v_synch    = 1'b1;
    bus.btn_start  = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;

    // act, n, state, run_en, score_l, score_r, serve_dir, game_over, winner
    add(A_MISS_L, 1, 0, 0, 0, 0, 0, 0, 0);
    add(A_FRAME,  1, 0, 0, 0, 0, 0, 0, 0);
    add(A_START,  1, 1, 0, 0, 0, 0, 0, 0);
    add(A_MISS_R, 1, 1, 0, 0, 0, 0, 0, 0);
    add(A_FRAME,  1, 1, 0, 0, 0, 0, 0, 0);
    add(A_FRAME,  1, 2, 1, 0, 0, 0, 0, 0);
    add(A_START,  1, 2, 1, 0, 0, 0, 0, 0);
    add(A_MISS_L, 1, 3, 0, 0, 1, 0, 0, 0);
    add(A_MISS_R, 1, 3, 0, 0, 1, 0, 0, 0);
    add(A_FRAME,  2, 3, 0, 0, 1, 0, 0, 0);
    add(A_FRAME,  1, 1, 0, 0, 1, 0, 0, 0);
    add(A_FRAME,  2, 2, 1, 0, 1, 0, 0, 0);
    add(A_MISS_B, 1, 1, 0, 0, 1, 0, 0, 0);
    add(A_FRAME,  2, 2, 1, 0, 1, 0, 0, 0);
    add(A_MISS_R, 1, 3, 0, 1, 1, 1, 0, 0);
    add(A_FRAME,  5, 2, 1, 1, 1, 1, 0, 0);
    add(A_MISS_B, 1, 1, 0, 1, 1, 1, 0, 0);
    add(A_FRAME,  2, 2, 1, 1, 1, 1, 0, 0);
    add(A_MISS_R, 1, 3, 0, 2, 1, 1, 0, 0);
    add(A_FRAME,  5, 2, 1, 2, 1, 1, 0, 0);
    add(A_MISS_R, 1, 4, 0, 3, 1, 1, 1, 0);
    add(A_MISS_R, 1, 4, 0, 3, 1, 1, 1, 0);
    add(A_MISS_L, 1, 4, 0, 3, 1, 1, 1, 0);
    add(A_FRAME,  1, 4, 0, 3, 1, 1, 1, 0);
    add(A_START,  1, 1, 0, 0, 0, 0, 0, 0);
    add(A_FRAME,  2, 2, 1, 0, 0, 0, 0, 0);
    add(A_MISS_L, 1, 3, 0, 0, 1, 0, 0, 0);
    add(A_FRAME,  5, 2, 1, 0, 1, 0, 0, 0);
    add(A_MISS_L, 1, 3, 0, 0, 2, 0, 0, 0);
    add(A_FRAME,  5, 2, 1, 0, 2, 0, 0, 0);
    add(A_MISS_L, 1, 4, 0, 0, 3, 0, 1, 1);

    step(3);
    check_idle("reset");
    check("reset_ball_serve", int'(bus.ball_serve), 0);
    check("reset_serve_dir", int'(bus.serve_dir), 0);
    Reset = 1'b1;
    step(2);

    foreach (vecs[i]) begin
      case (vecs[i].act)
        A_START:  do_start();
        A_FRAME:  do_frame(vecs[i].n);
        A_MISS_L: do_miss(1'b1, 1'b0);
        A_MISS_R: do_miss(1'b0, 1'b1);
        default:  do_miss(1'b1, 1'b1);
      endcase
      check($sformatf("row%0d_state", i), int'(bus.state), vecs[i].st);
      check($sformatf("row%0d_run_en", i), int'(bus.run_en), vecs[i].run);
      check($sformatf("row%0d_score_l", i), int'(bus.score_left), vecs[i].sl);
      check($sformatf("row%0d_score_r", i), int'(bus.score_right), vecs[i].sr);
      check($sformatf("row%0d_serve_dir", i), int'(bus.serve_dir), vecs[i].dir);
      check($sformatf("row%0d_game_over", i), int'(bus.game_over), vecs[i].over);
      if (vecs[i].over != 0)
        check($sformatf("row%0d_winner", i), int'(bus.winner), vecs[i].win);
    end

    // start from OVER: pin rises, acted on at the third clock edge
    bus.btn_start = 1'b1;
    step(2);
    check("start_lat_early_state", int'(bus.state), 4);
    step(1);
    check("start_lat_state", int'(bus.state), 1);
    check("start_lat_score_r", int'(bus.score_right), 0);
    bus.btn_start = 1'b0;
    step(4);

    // serve pulse on the second frame tick, exactly one cycle wide
    bus.v_synch = 1'b0;
    step(1);
    check("serve_tick1_state", int'(bus.state), 1);
    check("serve_tick1_pulse", int'(bus.ball_serve), 0);
    bus.v_synch = 1'b1;
    step(2);
    bus.v_synch = 1'b0;
    step(1);
    check("serve_tick2_state", int'(bus.state), 2);
    check("serve_tick2_pulse", int'(bus.ball_serve), 1);
    check("serve_tick2_run_en", int'(bus.run_en), 1);
    step(1);
    check("serve_pulse_end", int'(bus.ball_serve), 0);
    check("serve_after_state", int'(bus.state), 2);
    bus.v_synch = 1'b1;
    step(2);

    // miss_left held for 10 cycles scores once
    bus.miss_left = 1'b1;
    step(10);
    check("held_miss_score_r", int'(bus.score_right), 1);
    check("held_miss_score_l", int'(bus.score_left), 0);
    check("held_miss_state", int'(bus.state), 3);
    check("held_miss_dir", int'(bus.serve_dir), 0);
    bus.miss_left = 1'b0;
    step(2);
    do_frame(3);
    check("point_done_state", int'(bus.state), 1);
    do_frame(2);
    check("reserve_state", int'(bus.state), 2);

    // asynchronous reset in the middle of PLAY
    do_miss(1'b0, 1'b1);
    do_frame(5);
    check("pre_reset_state", int'(bus.state), 2);
    check("pre_reset_score_l", int'(bus.score_left), 1);
    Reset = 1'b0;
    #1;
    check_idle("async_reset");
    step(1);
    check_idle("reset_edge");
    Reset = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
